// File: rtl/lsu_dmem_master.sv
// Load/store initiator for a word-addressed dmem: sub-word extract/extend and store read-modify-write.
// Optional LSU_BOUNDS_CHECK_EN flags accesses whose upper address bits fall outside dmem.
module lsu_dmem_master #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dmem_r_addr,
  output logic [ADDR_W-1:0] dmem_w_addr,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [DATA_W-1:0] dmem_data_out,
  input  logic [DATA_W-1:0] dmem_data_in
);

  typedef enum logic [2:0] {StIdle, StRdIssue, StRdCapt, StWr, StResp} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          off_q, off_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                illegal, misaligned, out_of_range, req_err;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_W-1:0]   load_ext, store_merge;

  // Request error decode, evaluated combinationally on the incoming request.
  always_comb begin
    illegal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b1;
    endcase
    misaligned = 1'b0;
    if (req_funct3[1:0] == 2'b01) misaligned = req_addr[0];
    if (req_funct3 == 3'b010)     misaligned = (req_addr[1:0] != 2'b00);
  end

`ifdef LSU_BOUNDS_CHECK_EN
  assign out_of_range = |req_addr[31:ADDR_W+2];
`else
  logic unused_upper_addr;
  assign unused_upper_addr = ^req_addr[31:ADDR_W+2];
  assign out_of_range      = 1'b0;
`endif

  assign req_err = illegal | misaligned | out_of_range;

  // Lane extraction and merge operate on the word returned by dmem.
  always_comb begin
    byte_sel = 8'h00;
    unique case (off_q)
      2'd0: byte_sel = dmem_data_in[7:0];
      2'd1: byte_sel = dmem_data_in[15:8];
      2'd2: byte_sel = dmem_data_in[23:16];
      2'd3: byte_sel = dmem_data_in[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off_q[1] ? dmem_data_in[31:16] : dmem_data_in[15:0];

    load_ext = dmem_data_in;
    unique case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = dmem_data_in;
    endcase

    store_merge = dmem_data_in;
    if (f3_q[1:0] == 2'b00) begin
      unique case (off_q)
        2'd0: store_merge[7:0]   = wdata_q[7:0];
        2'd1: store_merge[15:8]  = wdata_q[7:0];
        2'd2: store_merge[23:16] = wdata_q[7:0];
        2'd3: store_merge[31:24] = wdata_q[7:0];
        default: store_merge = dmem_data_in;
      endcase
    end else if (f3_q[1:0] == 2'b01) begin
      if (off_q[1]) store_merge[31:16] = wdata_q[15:0];
      else          store_merge[15:0]  = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          off_d   = req_addr[1:0];
          waddr_d = req_addr[ADDR_W+1:2];
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)                             state_d = StResp;
          else if (req_we && req_funct3 == 3'b010) state_d = StWr;
          else                                     state_d = StRdIssue;
        end
      end
      StRdIssue: state_d = StRdCapt;
      StRdCapt: begin
        if (we_q) begin
          wdata_d = store_merge;
          state_d = StWr;
        end else begin
          rdata_d = load_ext;
          state_d = StResp;
        end
      end
      StWr: state_d = StResp;
      StResp: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from state so reset clears strobes immediately.
  assign req_ready     = (state_q == StIdle);
  assign resp_valid    = (state_q == StResp);
  assign resp_rdata    = (state_q == StResp) ? rdata_q : '0;
  assign resp_err      = (state_q == StResp) & err_q;
  assign dmem_read     = (state_q == StRdIssue);
  assign dmem_write    = (state_q == StWr);
  assign dmem_data_out = (state_q == StWr) ? wdata_q : '0;
  assign dmem_r_addr   = waddr_q;
  assign dmem_w_addr   = waddr_q;

`ifndef SYNTHESIS
  strobe_excl_a: assert property (@(posedge clk) disable iff (!rst_n) !(dmem_read && dmem_write));
`endif

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed self-checking bench for lsu_dmem_master with a behavioural sync-write/registered-read dmem.
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [4:0]  dmem_r_addr, dmem_w_addr;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_data_out;
  logic [31:0] dmem_data_in;

  logic [31:0] mem [32];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmem_write) mem[dmem_w_addr] <= dmem_data_out;
    if (dmem_read)  dmem_data_in <= mem[dmem_r_addr];
  end

  lsu_dmem_master #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .dmem_r_addr(dmem_r_addr), .dmem_w_addr(dmem_w_addr),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_data_out(dmem_data_out), .dmem_data_in(dmem_data_in)
  );

  // Drives one request and reports what was observed; latency counted from the accept edge.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                      output int lat, output int nrd, output int nwr,
                      output logic [4:0] waddr, output logic [31:0] wword);
    rdata = 32'h0; err = 1'b0; lat = 99; nrd = 0; nwr = 0; waddr = 5'h0; wword = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (dmem_read) nrd++;
      if (dmem_write) begin nwr++; waddr = dmem_w_addr; wword = dmem_data_out; end
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dmem_read !== 1'b0 ||
        dmem_write !== 1'b0 || dmem_data_out !== 32'h0 || resp_rdata !== 32'h0 ||
        resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b rv=%b rd=%b wr=%b dout=%h rdata=%h err=%b required rdy=1 rest 0",
               req_ready, resp_valid, dmem_read, dmem_write, dmem_data_out, resp_rdata, resp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] rd, ww; logic er; int lat, nr, nw; logic [4:0] wa;
    xact(1'b1, 3'b010, 32'h04, 32'h0000000A, rd, er, lat, nr, nw, wa, ww);
    checks++;
    if (nw !== 1 || nr !== 0 || wa !== 5'd1 || ww !== 32'hA || lat !== 2 || er !== 1'b0) begin
      errors++;
      $display("FAIL sw: nwr=%0d nrd=%0d waddr=%0d wdata=%h lat=%0d err=%b required 1 0 1 0000000a 2 0",
               nw, nr, wa, ww, lat, er);
    end
    xact(1'b0, 3'b010, 32'h04, 32'h0, rd, er, lat, nr, nw, wa, ww);
    checks++;
    if (rd !== 32'h0000000A || lat !== 3 || nr !== 1 || nw !== 0 || er !== 1'b0) begin
      errors++;
      $display("FAIL lw: rdata=%h lat=%0d nrd=%0d nwr=%0d err=%b required 0000000a 3 1 0 0",
               rd, lat, nr, nw, er);
    end
  endtask

  task automatic test_subword_load();
    logic [31:0] rd, ww; logic er; int lat, nr, nw; logic [4:0] wa;
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adrs [4] = '{32'h09, 32'h09, 32'h0A, 32'h0A};
    logic [31:0] exps [4] = '{32'hFFFFFFF6, 32'h000000F6, 32'hFFFF8877, 32'h00008877};
    xact(1'b1, 3'b010, 32'h08, 32'h8877F655, rd, er, lat, nr, nw, wa, ww);
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, f3s[i], adrs[i], 32'h0, rd, er, lat, nr, nw, wa, ww);
      checks++;
      if (rd !== exps[i] || lat !== 3 || er !== 1'b0) begin
        errors++;
        $display("FAIL subload%0d: rdata=%h lat=%0d err=%b required %h 3 0",
                 i, rd, lat, er, exps[i]);
      end
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd, ww; logic er; int lat, nr, nw; logic [4:0] wa;
    xact(1'b1, 3'b010, 32'h04, 32'h11223344, rd, er, lat, nr, nw, wa, ww);
    xact(1'b1, 3'b000, 32'h06, 32'h000000AB, rd, er, lat, nr, nw, wa, ww);
    checks++;
    if (nr !== 1 || nw !== 1 || wa !== 5'd1 || ww !== 32'h11AB3344 || lat !== 4 || er !== 1'b0) begin
      errors++;
      $display("FAIL sb: nrd=%0d nwr=%0d waddr=%0d wdata=%h lat=%0d err=%b required 1 1 1 11ab3344 4 0",
               nr, nw, wa, ww, lat, er);
    end
    xact(1'b0, 3'b010, 32'h04, 32'h0, rd, er, lat, nr, nw, wa, ww);
    checks++;
    if (rd !== 32'h11AB3344) begin
      errors++;
      $display("FAIL sb_reread: rdata=%h required 11ab3344", rd);
    end
    xact(1'b1, 3'b010, 32'h0C, 32'h12345678, rd, er, lat, nr, nw, wa, ww);
    xact(1'b1, 3'b001, 32'h0E, 32'h0000BEEF, rd, er, lat, nr, nw, wa, ww);
    checks++;
    if (ww !== 32'hBEEF5678 || wa !== 5'd3 || lat !== 4) begin
      errors++;
      $display("FAIL sh: wdata=%h waddr=%0d lat=%0d required beef5678 3 4", ww, wa, lat);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, ww; logic er; int lat, nr, nw; logic [4:0] wa;
    logic        wes  [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s  [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] adrs [3] = '{32'h06, 32'h03, 32'h00};
    for (int i = 0; i < 3; i++) begin
      xact(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, rd, er, lat, nr, nw, wa, ww);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || nr !== 0 || nw !== 0) begin
        errors++;
        $display("FAIL err%0d: err=%b rdata=%h lat=%0d nrd=%0d nwr=%0d required 1 0 1 0 0",
                 i, er, rd, lat, nr, nw);
      end
    end
    xact(1'b1, 3'b100, 32'h00, 32'h0, rd, er, lat, nr, nw, wa, ww);
    checks++;
    if (er !== 1'b1 || nw !== 0 || nr !== 0) begin
      errors++;
      $display("FAIL store_1xx: err=%b nrd=%0d nwr=%0d required 1 0 0", er, nr, nw);
    end
  endtask

  task automatic test_bounds();
    logic [31:0] rd, ww; logic er; int lat, nr, nw; logic [4:0] wa;
    xact(1'b1, 3'b010, 32'h00, 32'hCAFE0001, rd, er, lat, nr, nw, wa, ww);
    xact(1'b0, 3'b010, 32'h80, 32'h0, rd, er, lat, nr, nw, wa, ww);
    checks++;
`ifdef LSU_BOUNDS_CHECK_EN
    if (er !== 1'b1 || rd !== 32'h0 || nr !== 0 || lat !== 1) begin
      errors++;
      $display("FAIL bounds: err=%b rdata=%h nrd=%0d lat=%0d required 1 0 0 1", er, rd, nr, lat);
    end
`else
    if (er !== 1'b0 || rd !== 32'hCAFE0001 || nr !== 1 || lat !== 3) begin
      errors++;
      $display("FAIL wrap: err=%b rdata=%h nrd=%0d lat=%0d required 0 cafe0001 1 3", er, rd, nr, lat);
    end
`endif
  endtask

  task automatic test_stall_and_reset();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h08;
    @(posedge clk);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) seen = 1;
    end
    checks++;
    if (seen !== 1) begin errors++; $display("FAIL stall_resp: resp_valid never seen required 1"); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h8877F655 || resp_err !== 1'b0 ||
          req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d: rv=%b rdata=%h err=%b rdy=%b required 1 8877f655 0 0",
                 c, resp_valid, resp_rdata, resp_err, req_ready);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: rv=%b rdata=%h rdy=%b required 0 0 1", resp_valid, resp_rdata, req_ready);
    end

    // Sub-word store to word 2, interrupted by reset while the write strobe is up.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h08; req_wdata = 32'h11;
    @(posedge clk);
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (dmem_write) seen = 1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (seen !== 1 || dmem_write !== 1'b0 || req_ready !== 1'b1 || dmem_data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_wr: seen=%0d wr=%b rdy=%b dout=%h required 1 0 1 0",
               seen, dmem_write, req_ready, dmem_data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (mem[2] !== 32'h8877F655) begin
      errors++;
      $display("FAIL reset_no_write: mem2=%h required 8877f655", mem[2]);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_load();
    test_subword_store();
    test_errors();
    test_bounds();
    test_stall_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
